super_counter_uart_tx: RTL
==========================

// Module: super_counter_uart_tx
// PURPOSE
//  Transmit side of the super counter: on each send strobe, snapshot a 16-bit count and emit
//  ASCII "BTN:hhhh\r\n" (uppercase hex, MSB nibble first) as 8N1 UART on uart_tx.
//  Sits beside the button debouncer and counter; send is driven by the press pulse,
//  value by btn_count. One-deep pending slot absorbs presses during a message.
// PARAMETERS
//  CLK_HZ   12_000_000  clock frequency in Hz
//  BAUD     115_200     line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 104 at defaults, must be >= 2)
// PORTS
//  clk_12m   in   1   single clock, rising edge
//  rst_n     in   1   reset, asynchronous, active-low
//  send      in   1   1-cycle request; samples value in the same cycle
//  value     in   16  count to format
//  uart_tx   out  1   serial line, idle high
//  busy      out  1   high while a message is in flight or one is pending
//  dropped   out  1   1-cycle pulse when a pending request is overwritten
// BEHAVIOUR
//  - Reset (async, while rst_n=0): uart_tx=1, busy=0, dropped=0, pending empty, both FSMs idle.
//    Applies immediately mid-frame; the truncated frame is not resumed.
//  - Frame: 8N1, LSB first; start(0), d0..d7, stop(1), each exactly CLKS_PER_BIT cycles.
//  - Message: 10 bytes, back-to-back, no idle gap: 0x42 0x54 0x4E 0x3A h3 h2 h1 h0 0x0D 0x0A;
//    hN = nibble N of the snapshot: 0-9 -> 0x30+n, A-F -> 0x41+(n-10).
//    Duration = 100*CLKS_PER_BIT cycles (10400 at defaults).
//  - Accept: send=1 while idle -> snapshot value; busy=1 and uart_tx=0 (start bit)
//    from the next cycle.
//  - send=1 while a message is in flight -> value stored in pending slot. If already
//    pending: overwrite with the newer value and pulse dropped the next cycle.
//  - Stop bit of byte 10 ends with pending set -> next message's start bit in the next
//    cycle (no gap); pending clears, busy stays 1.
//  - send in the same cycle that the last stop bit ends -> treated as pending; starts
//    with no gap.
//  - busy falls in the first cycle after the final stop bit when nothing is pending.
//  - Message FSM: IDLE -> LOAD (select byte idx) -> WAIT (byte busy) -> LOAD (idx+1)
//    or, after idx 9, IDLE / LOAD(idx 0 of pending).
//    LOAD-to-start latency is absorbed so inter-byte gap is 0.
//  - Byte FSM: IDLE -> START -> DATA (8 bits, bit counter 0..7) -> STOP -> IDLE, or
//    directly -> START when the next byte is presented in the last stop-bit cycle.
//    Baud counter counts 0..CLKS_PER_BIT-1 and reloads at 0 on each bit.
//  - Widths: baud counter $clog2(CLKS_PER_BIT); byte index 4 bits, 0..9; no
//    wrap-around beyond 9. Hex of 0x0000 = "0000", 0xFFFF = "FFFF".
// STRUCTURE
//  - super_counter_pkg: MSG_LEN=10; typedef msg_idx_t (logic[3:0]);
//    function clks_per_bit(CLK_HZ, BAUD); function hex_ascii(logic[3:0]) -> logic[7:0];
//    enum types msg_state_t, tx_state_t.
//  - Sub-module uart_tx_byte (CLKS_PER_BIT): ports clk_12m, rst_n, tx_valid, tx_data[7:0],
//    tx_ready, uart_tx. Ready/valid: byte is taken on valid&&ready. ready is high in IDLE
//    and in the last stop-bit cycle.
//  - Top: snapshot + pending register, message FSM, byte mux, dropped pulse.
// TESTING
//  1. Hold rst_n=0 10 cycles, then release -> uart_tx=1, busy=0, dropped=0 throughout.
//  2. send with value=16'h1A2B -> start edge 1 cycle later; decoded bytes
//     42 54 4E 3A 31 41 32 42 0D 0A; every bit 104 cycles; busy=0 exactly 10400 cycles
//     after the start edge.
//  3. CLK_HZ=1000, BAUD=250, value=16'h0000 then (idle) 16'hFFFF -> "BTN:0000\r\n" then
//     "BTN:FFFF\r\n". Each bit 4 cycles, each message 400 cycles.
//  4. Mid-message: send 16'h0005, then 16'h0006, then 16'h0007 -> one dropped pulse
//     (on 0007). Second message "BTN:0007\r\n" starts with zero gap; busy stays 1 across
//     both messages.
//  5. rst_n=0 asynchronously in the middle of a data bit -> uart_tx=1 and busy=0 before
//     the next clock edge. After release, send 16'h00C3 -> clean "BTN:00C3\r\n".
//  6. send coincident with the final stop-bit cycle -> next start bit in the next cycle;
//     no dropped pulse; busy never deasserts.

Source files
------------

// File: rtl/super_counter_pkg.sv
// Shared types and helpers for the super counter UART transmit path:
// message layout, hex formatting and baud divisor arithmetic.
package super_counter_pkg;

  localparam int unsigned MSG_LEN = 10;

  typedef logic [3:0] msg_idx_t;

  localparam msg_idx_t LAST_IDX = msg_idx_t'(MSG_LEN - 1);

  typedef enum logic [0:0] {
    MSG_IDLE,
    MSG_WAIT
  } msg_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // 0-9 -> '0'..'9', A-F -> 'A'..'F' ('A' - 10 = 0x37).
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte idx of the message "BTN:hhhh\r\n" for snapshot v.
  function automatic logic [7:0] msg_byte(input msg_idx_t idx, input logic [15:0] v);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h42;
      4'd1:    b = 8'h54;
      4'd2:    b = 8'h4E;
      4'd3:    b = 8'h3A;
      4'd4:    b = hex_ascii(v[15:12]);
      4'd5:    b = hex_ascii(v[11:8]);
      4'd6:    b = hex_ascii(v[7:4]);
      4'd7:    b = hex_ascii(v[3:0]);
      4'd8:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a ready/valid input. Ready is also raised in the
// last stop-bit cycle so a following byte starts with no idle gap.
module uart_tx_byte
  import super_counter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk_12m,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign tx_ready  = (state == TX_IDLE) || ((state == TX_STOP) && baud_last);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (tx_valid) begin
            state    <= TX_START;
            shift    <= tx_data;
            baud_cnt <= '0;
            uart_tx  <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_last) begin
            state    <= TX_DATA;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            uart_tx  <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state   <= TX_STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              uart_tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (tx_valid) begin
              state   <= TX_START;
              shift   <= tx_data;
              uart_tx <= 1'b0;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state   <= TX_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/super_counter_uart_tx.sv
// Formats a 16-bit count snapshot as "BTN:hhhh\r\n" and sends it as 8N1 UART,
// with a one-deep pending slot for requests that arrive mid-message.
module super_counter_uart_tx
  import super_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 12_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic        clk_12m,
  input  logic        rst_n,
  input  logic        send,
  input  logic [15:0] value,
  output logic        uart_tx,
  output logic        busy,
  output logic        dropped
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  msg_state_t  msg_state;
  msg_idx_t    idx;
  logic [15:0] snapshot;
  logic        pend_valid;
  logic [15:0] pend_value;

  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  msg_idx_t    sel_idx;
  logic [15:0] sel_val;
  logic        last_done;

  assign last_done = tx_ready && (idx == LAST_IDX);

  // The LOAD step happens in the handshake cycle itself: the next byte is
  // offered while the serializer is idle or finishing its stop bit.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tx_valid = 1'b0;
    sel_idx  = idx;
    sel_val  = snapshot;
    case (msg_state)
      MSG_IDLE: begin
        if (send) begin
          tx_valid = 1'b1;
          sel_idx  = '0;
          sel_val  = value;
        end
      end
      MSG_WAIT: begin
        if (tx_ready) begin
          if (idx != LAST_IDX) begin
            tx_valid = 1'b1;
            sel_idx  = idx + 1'b1;
          end else if (send || pend_valid) begin
            tx_valid = 1'b1;
            sel_idx  = '0;
            sel_val  = send ? value : pend_value;
          end
        end
      end
      default: ;
    endcase
  end

  assign tx_data = msg_byte(sel_idx, sel_val);

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      msg_state  <= MSG_IDLE;
      idx        <= '0;
      snapshot   <= '0;
      pend_valid <= 1'b0;
      pend_value <= '0;
      busy       <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      dropped <= 1'b0;
      case (msg_state)
        MSG_IDLE: begin
          if (send) begin
            msg_state <= MSG_WAIT;
            idx       <= '0;
            snapshot  <= value;
            busy      <= 1'b1;
          end
        end
        MSG_WAIT: begin
          if (last_done) begin
            // A send in the final stop-bit cycle behaves like a pending request.
            if (send || pend_valid) begin
              snapshot   <= send ? value : pend_value;
              idx        <= '0;
              pend_valid <= 1'b0;
              dropped    <= send && pend_valid;
            end else begin
              msg_state <= MSG_IDLE;
              busy      <= 1'b0;
            end
          end else begin
            if (tx_ready) idx <= idx + 1'b1;
            if (send) begin
              pend_valid <= 1'b1;
              pend_value <= value;
              dropped    <= pend_valid;
            end
          end
        end
        default: begin
          msg_state <= MSG_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk_12m (clk_12m),
    .rst_n   (rst_n),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .uart_tx (uart_tx)
  );

endmodule
